memory_loader: RTL and testbench
================================

Name: memory_loader

Overview:
- Write-side counterpart to the team's synchronous ROM/RAM read blocks.
- Accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into MEMORY_WIDTH-bit words.
- Drives a one-cycle-per-word synchronous write port into instruction/data memory at consecutive addresses from 0.
- Used at boot to fill program memory before the core leaves reset.

Parameters:
- MEMORY_WIDTH, 16: word width in bits; must be a multiple of 8; BYTES_PER_WORD = MEMORY_WIDTH/8.
- MEMORY_DEPTH, 8: number of words in the target memory; upper bound on the load length.
- ADDRESS_WIDTH, 8: width of write_address.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  load request; sampled only in IDLE.
- word_count  input  ADDRESS_WIDTH+1  number of words to load; latched on accepted start.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- write_enable  output  1  memory write strobe.
- write_address  output  ADDRESS_WIDTH  memory word address.
- write_data  output  MEMORY_WIDTH  memory word.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at the end of a load.
- error  output  1  sticky flag: rejected start (word_count > MEMORY_DEPTH).

Behaviour:
- One clock; reset is synchronous and active-low: reset_n sampled low at a rising clock edge resets the block.
- Reset action:
  - state goes to IDLE.
  - in_ready, write_enable, busy, done, error, write_address, write_data all go to 0.
  - Any partially packed word is discarded.
  - No write is issued in the cycle after reset.
- All outputs are registered except in_ready and busy, which are decoded from state.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored and no byte is consumed.
  - start=1 clears error and latches word_count.
  - word_count==0: go to DONE.
  - word_count>MEMORY_DEPTH: set error=1, stay in IDLE.
  - Otherwise: go to COLLECT with address=0 and byte_index=0.
- COLLECT:
  - in_ready=1.
  - A byte transfers when in_valid && in_ready at a clock edge.
  - The byte goes into bits [8*byte_index+7 : 8*byte_index] of the pack register; byte_index increments.
  - On the transfer with byte_index==BYTES_PER_WORD-1: go to WRITE and reset byte_index to 0.
  - in_valid low: hold state; the partial word is kept indefinitely (no timeout).
- WRITE:
  - Exactly one cycle with write_enable=1, write_address=address, write_data=packed word; in_ready=0.
  - Next state is DONE if address==word_count-1, otherwise COLLECT with address+1.
- DONE: done=1 for exactly one cycle; busy=1; then go to IDLE.
- write_address and write_data hold their last values while write_enable=0.
- start outside IDLE is ignored; word_count is not re-latched mid-load.
- Throughput: at most one word per BYTES_PER_WORD+1 cycles. The first write_enable occurs BYTES_PER_WORD+1 cycles after the start edge when in_valid is held high.
- Address never wraps. The load ends exactly at word_count-1, and word_count<=MEMORY_DEPTH is guaranteed by the start check.
- Simultaneous start and in_valid in IDLE: only start is acted on; the byte is not consumed until COLLECT.
- reset_n low in any state overrides all other inputs.

Test Plan:
- Basic load: MEMORY_WIDTH=16, start with word_count=3, in_valid held high, bytes 11 22 33 44 55 66.
  -> writes addr0=0x2211, addr1=0x4433, addr2=0x6655; each write_enable exactly 1 cycle; first write 3 cycles after start; done pulses the cycle after the last write, then busy=0.
- Stream gaps: same load with in_valid toggled 1,0,0,1 per byte.
  -> identical memory contents; no write issued before both bytes of a word have transferred; in_ready=0 during every WRITE cycle.
- Length boundaries:
  - word_count=0 -> done=1 in the cycle after start, no write_enable.
  - word_count=8 (=MEMORY_DEPTH) -> 8 writes at addresses 0..7.
  - word_count=9 -> error=1, busy stays 0, no write; a following valid start clears error.
- Reset mid-word: reset_n=0 after byte 0x11 of word 0 is accepted.
  -> all outputs 0 next cycle, no write; a new load of AA BB writes addr0=0xBBAA.
- Start ignored while busy: pulse start with word_count=5 during a 2-word load.
  -> exactly 2 writes, single done pulse, no restart.
- Idle stream: in_valid=1 with in_data=0xFF while in IDLE.
  -> in_ready stays 0; after start, the first consumed byte is the one presented in COLLECT.

Source files
------------

// File: rtl/memory_loader.sv
// Boot-time memory loader: packs a valid/ready byte stream little-endian into
// MEMORY_WIDTH-bit words and writes them to consecutive addresses from 0.
module memory_loader #(
  parameter int MEMORY_WIDTH  = 16,
  parameter int MEMORY_DEPTH  = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [MEMORY_WIDTH-1:0]  write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int BYTES_PER_WORD = MEMORY_WIDTH / 8;
  localparam int INDEX_WIDTH    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [INDEX_WIDTH-1:0]   LAST_INDEX  = INDEX_WIDTH'(BYTES_PER_WORD - 1);
  localparam logic [INDEX_WIDTH-1:0]   INDEX_ONE   = INDEX_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_ONE = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   COUNT_ONE   = (ADDRESS_WIDTH + 1)'(1);
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                   state_q,    state_d;
  logic [ADDRESS_WIDTH:0]   count_q,    count_d;
  logic [ADDRESS_WIDTH-1:0] address_q,  address_d;
  logic [INDEX_WIDTH-1:0]   index_q,    index_d;
  logic [MEMORY_WIDTH-1:0]  pack_q,     pack_d;
  logic                     we_q,       we_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [MEMORY_WIDTH-1:0]  wr_data_q,  wr_data_d;
  logic                     done_q,     done_d;
  logic                     error_q,    error_d;

  logic                     transfer;
  logic                     last_word;
  logic [ADDRESS_WIDTH:0]   last_address;
  logic [MEMORY_WIDTH-1:0]  pack_merged;

  assign in_ready     = (state_q == COLLECT);
  assign busy         = (state_q != IDLE);
  assign transfer     = in_ready && in_valid;
  assign last_address = count_q - COUNT_ONE;
  assign last_word    = ({1'b0, address_q} == last_address);

  // Each byte lane captures the incoming byte only when it is the lane being filled,
  // so the merged word already contains the final byte on the completing transfer.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign pack_merged[8*gi +: 8] =
        (transfer && (index_q == INDEX_WIDTH'(gi))) ? in_data : pack_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    address_d = address_q;
    index_d   = index_q;
    pack_d    = pack_q;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          count_d = word_count;
          if (word_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (word_count > DEPTH_LIMIT) begin
            error_d = 1'b1;
          end else begin
            state_d   = COLLECT;
            address_d = '0;
            index_d   = '0;
          end
        end
      end

      COLLECT: begin
        if (transfer) begin
          pack_d = pack_merged;
          if (index_q == LAST_INDEX) begin
            index_d   = '0;
            state_d   = WRITE;
            we_d      = 1'b1;
            wr_addr_d = address_q;
            wr_data_d = pack_merged;
          end else begin
            index_d = index_q + INDEX_ONE;
          end
        end
      end

      WRITE: begin
        if (last_word) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d   = COLLECT;
          address_d = address_q + ADDRESS_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      address_q <= '0;
      index_q   <= '0;
      pack_q    <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      address_q <= address_d;
      index_q   <= index_d;
      pack_q    <= pack_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = wr_addr_q;
  assign write_data    = wr_data_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_memory_loader.sv
// Directed self-checking bench for memory_loader (16-bit words, depth 8).
module tb_memory_loader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [8:0]  word_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        write_enable;
  logic [7:0]  write_address;
  logic [15:0] write_data;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  // Write/transfer monitor, sampled on the falling edge
  int          n_wr = 0;
  int          n_done = 0;
  int          n_xfer = 0;
  int          last_xfer = 0;
  int          n_early = 0;
  int          n_rdy_in_write = 0;
  logic [7:0]  cap_addr [0:63];
  logic [15:0] cap_data [0:63];
  logic [7:0]  bytes_arr [0:15];

  memory_loader #(
    .MEMORY_WIDTH (16),
    .MEMORY_DEPTH (8),
    .ADDRESS_WIDTH(8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .word_count   (word_count),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (in_valid && in_ready) n_xfer <= n_xfer + 1;
    if (write_enable) begin
      if (n_wr < 64) begin
        cap_addr[n_wr] <= write_address;
        cap_data[n_wr] <= write_data;
      end
      n_wr <= n_wr + 1;
      if (in_ready) n_rdy_in_write <= n_rdy_in_write + 1;
      if (n_xfer - last_xfer < 2) n_early <= n_early + 1;
      last_xfer <= n_xfer;
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit xfer;
    int guard;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    xfer     = 1'b0;
    while (!xfer && guard < 50) begin
      xfer = in_ready;
      tick();
      guard++;
    end
    if (!xfer) check("byte_accept_timeout", 32'(xfer), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (!done && guard < 60) begin
      tick();
      guard++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // Byte k of the load comes from bytes_arr[k]; gap inserts two idle cycles before odd bytes
  task automatic run_load(input int wc, input bit gap);
    start      = 1'b1;
    word_count = 9'(wc);
    tick();
    start = 1'b0;
    for (int k = 0; k < 2 * wc; k++) begin
      send_byte(bytes_arr[k], (gap && (k % 2 == 1)) ? 2 : 0);
    end
    in_valid = 1'b0;
    wait_done("load");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int wb;
    int db;
    int xb;

    reset_n    = 1'b0;
    start      = 1'b0;
    word_count = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", 32'(write_address), 32'd0);
    check("rst_data", 32'(write_data), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic load with exact cycle timing; start and a valid byte arrive together
    wb = n_wr; db = n_done;
    start = 1'b1; word_count = 9'd3; in_valid = 1'b1; in_data = 8'h11;
    tick();
    start = 1'b0;
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_ready", 32'(in_ready), 32'd1);
    check("basic_we_c1", 32'(write_enable), 32'd0);
    tick();
    in_data = 8'h22;
    check("basic_we_c2", 32'(write_enable), 32'd0);
    tick();
    check("basic_we_w0", 32'(write_enable), 32'd1);
    check("basic_addr_w0", 32'(write_address), 32'h0);
    check("basic_data_w0", 32'(write_data), 32'h2211);
    check("basic_ready_w0", 32'(in_ready), 32'd0);
    in_data = 8'h33;
    tick();
    check("basic_we_off", 32'(write_enable), 32'd0);
    check("basic_addr_hold", 32'(write_address), 32'h0);
    check("basic_data_hold", 32'(write_data), 32'h2211);
    tick();
    in_data = 8'h44;
    tick();
    check("basic_we_w1", 32'(write_enable), 32'd1);
    check("basic_addr_w1", 32'(write_address), 32'h1);
    check("basic_data_w1", 32'(write_data), 32'h4433);
    in_data = 8'h55;
    tick();
    tick();
    in_data = 8'h66;
    tick();
    check("basic_we_w2", 32'(write_enable), 32'd1);
    check("basic_addr_w2", 32'(write_address), 32'h2);
    check("basic_data_w2", 32'(write_data), 32'h6655);
    in_valid = 1'b0;
    tick();
    check("basic_done", 32'(done), 32'd1);
    check("basic_done_busy", 32'(busy), 32'd1);
    check("basic_done_we", 32'(write_enable), 32'd0);
    tick();
    check("basic_done_off", 32'(done), 32'd0);
    check("basic_idle_busy", 32'(busy), 32'd0);
    check("basic_nwrites", 32'(n_wr - wb), 32'd3);
    check("basic_ndone", 32'(n_done - db), 32'd1);

    // Stream gaps: same contents, no early write, in_ready low during writes
    bytes_arr[0] = 8'h11; bytes_arr[1] = 8'h22; bytes_arr[2] = 8'h33;
    bytes_arr[3] = 8'h44; bytes_arr[4] = 8'h55; bytes_arr[5] = 8'h66;
    wb = n_wr;
    run_load(3, 1'b1);
    check("gap_nwrites", 32'(n_wr - wb), 32'd3);
    check("gap_data0", 32'(cap_data[wb]), 32'h2211);
    check("gap_data1", 32'(cap_data[wb + 1]), 32'h4433);
    check("gap_data2", 32'(cap_data[wb + 2]), 32'h6655);
    check("gap_addr2", 32'(cap_addr[wb + 2]), 32'h2);
    check("gap_early_writes", 32'(n_early), 32'd0);
    check("gap_ready_in_write", 32'(n_rdy_in_write), 32'd0);

    // Oversized request is rejected and sticky; a zero-length start clears it
    wb = n_wr;
    start = 1'b1; word_count = 9'd9;
    tick();
    start = 1'b0;
    check("over_error", 32'(error), 32'd1);
    check("over_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("over_error_sticky", 32'(error), 32'd1);
    check("over_busy_idle", 32'(busy), 32'd0);
    start = 1'b1; word_count = 9'd0;
    tick();
    start = 1'b0;
    check("zero_error_clear", 32'(error), 32'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd1);
    tick();
    check("zero_done_off", 32'(done), 32'd0);
    check("zero_busy_off", 32'(busy), 32'd0);
    check("over_zero_nwrites", 32'(n_wr - wb), 32'd0);

    // Full-depth load: word i = {0x10+2i+1, 0x10+2i}
    for (int k = 0; k < 16; k++) bytes_arr[k] = 8'(8'h10 + k);
    wb = n_wr;
    run_load(8, 1'b0);
    check("full_nwrites", 32'(n_wr - wb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("full_addr", 32'(cap_addr[wb + i]), 32'(i));
      check("full_data", 32'(cap_data[wb + i]), 32'({8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)}));
    end

    // Reset after the first byte of a word
    wb = n_wr;
    start = 1'b1; word_count = 9'd2; in_valid = 1'b1; in_data = 8'h11;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0; in_valid = 1'b0;
    tick();
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_we", 32'(write_enable), 32'd0);
    check("mid_rst_addr", 32'(write_address), 32'd0);
    check("mid_rst_data", 32'(write_data), 32'd0);
    reset_n = 1'b1;
    tick();
    check("mid_rst_nowrite", 32'(n_wr - wb), 32'd0);
    bytes_arr[0] = 8'hAA; bytes_arr[1] = 8'hBB;
    run_load(1, 1'b0);
    check("mid_rst_nwrites", 32'(n_wr - wb), 32'd1);
    check("mid_rst_addr0", 32'(cap_addr[wb]), 32'h0);
    check("mid_rst_data0", 32'(cap_data[wb]), 32'hBBAA);

    // Start pulsed during a 2-word load is ignored
    wb = n_wr; db = n_done;
    start = 1'b1; word_count = 9'd2; in_valid = 1'b1; in_data = 8'h31;
    tick();
    start = 1'b0;
    tick();
    in_data = 8'h32; start = 1'b1; word_count = 9'd5;
    tick();
    start = 1'b0;
    send_byte(8'h33, 0);
    send_byte(8'h34, 0);
    in_valid = 1'b0;
    wait_done("busy_start");
    tick();
    tick();
    check("busy_start_nwrites", 32'(n_wr - wb), 32'd2);
    check("busy_start_ndone", 32'(n_done - db), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);
    check("busy_start_data0", 32'(cap_data[wb]), 32'h3231);
    check("busy_start_data1", 32'(cap_data[wb + 1]), 32'h3433);

    // Idle stream is not consumed; first byte taken is the one shown in COLLECT
    wb = n_wr; xb = n_xfer;
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ready", 32'(in_ready), 32'd0);
    end
    check("idle_no_xfer", 32'(n_xfer - xb), 32'd0);
    start = 1'b1; word_count = 9'd1;
    tick();
    start = 1'b0; in_data = 8'h5A;
    tick();
    in_data = 8'hA5;
    tick();
    check("idle_we", 32'(write_enable), 32'd1);
    check("idle_addr", 32'(write_address), 32'h0);
    check("idle_data", 32'(write_data), 32'hA55A);
    in_valid = 1'b0;
    wait_done("idle");
    check("idle_nwrites", 32'(n_wr - wb), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
